// File: rtl/tcdm_bank_pkg.sv
// TCDM bank arbiter shared types: payload field offsets and request layout.
// Optional registered read data: define TCDM_BANK_ARB_RDATA_REG_EN.
package tcdm_bank_pkg;

  localparam int unsigned DEF_BE_W   = 4;
  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 32;

  function automatic int unsigned WEN_POS(
    input int unsigned be_w,
    input int unsigned addr_w,
    input int unsigned data_w
  );
    return be_w + addr_w + data_w;
  endfunction

  function automatic int unsigned BE_LSB(
    input int unsigned addr_w,
    input int unsigned data_w
  );
    return addr_w + data_w;
  endfunction

  function automatic int unsigned ADDR_LSB(
    input int unsigned data_w
  );
    return data_w;
  endfunction

  function automatic int unsigned WDATA_LSB();
    return 0;
  endfunction

  typedef struct packed {
    logic                  wen;
    logic [DEF_BE_W-1:0]   be;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } tcdm_bank_req_t;

endpackage

// File: rtl/tcdm_rr_prio_sel.sv
// Wrap-around priority search: first set req bit at or after ptr.
// Pure combinational; the caller owns the pointer register.
module tcdm_rr_prio_sel #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [PtrW-1:0] sel,
  output logic            valid,
  output logic [N-1:0]    onehot
);

  int unsigned     k;
  logic [PtrW-1:0] kk;

  always_comb begin
    sel    = ptr;
    valid  = 1'b0;
    onehot = '0;
    k      = 0;
    kk     = '0;
    for (int i = 0; i < N; i++) begin
      k = 32'(ptr) + 32'(i);
      // explicit wrap keeps non-power-of-two N correct
      if (k >= N) k = k - N;
      kk = k[PtrW-1:0];
      if (!valid && req[kk]) begin
        valid = 1'b1;
        sel   = kk;
      end
    end
    if (valid) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/tcdm_bank_arb.sv
// Per-bank round-robin arbiter driving a single-port SRAM macro.
// Define TCDM_BANK_ARB_RDATA_REG_EN to register read data (latency 2).
module tcdm_bank_arb
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned NumIn        = 32,
  parameter int unsigned AddrWidth    = 10,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned ReqDataWidth = 1 + BeWidth + AddrWidth + DataWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumIn-1:0]                    req_i,
  output logic [NumIn-1:0]                    gnt_o,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]  data_i,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                mem_req_o,
  output logic                                mem_we_o,
  output logic [BeWidth-1:0]                  mem_be_o,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic [DataWidth-1:0]                mem_wdata_o,
  input  logic [DataWidth-1:0]                mem_rdata_i
);

  localparam int unsigned PtrW =
    (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned WenPos =
    WEN_POS(BeWidth, AddrWidth, DataWidth);
  localparam int unsigned BeLsb = BE_LSB(AddrWidth, DataWidth);
  localparam int unsigned AddrLsb = ADDR_LSB(DataWidth);
  localparam int unsigned WdataLsb = WDATA_LSB();

  logic [PtrW-1:0]         rr_q;
  logic [PtrW-1:0]         sel;
  logic                    valid;
  logic [ReqDataWidth-1:0] pay;

  tcdm_rr_prio_sel #(
    .N    (NumIn),
    .PtrW (PtrW)
  ) u_sel (
    .req    (req_i),
    .ptr    (rr_q),
    .sel    (sel),
    .valid  (valid),
    .onehot (gnt_o)
  );

  // idle: sel falls back to rr_q, so the payload is don't-care
  assign pay         = data_i[sel];
  assign mem_req_o   = |req_i;
  assign mem_we_o    = pay[WenPos];
  assign mem_be_o    = pay[BeLsb +: BeWidth];
  assign mem_addr_o  = pay[AddrLsb +: AddrWidth];
  assign mem_wdata_o = pay[WdataLsb +: DataWidth];

  if (NumIn == 1) begin : g_single
    assign rr_q = '0;
  end else begin : g_rr
    logic [PtrW-1:0] rr_d;

    assign rr_d = (sel == PtrW'(NumIn - 1)) ?
                  '0 : sel + PtrW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_q <= '0;
      else if (valid) rr_q <= rr_d;
    end
  end

`ifdef TCDM_BANK_ARB_RDATA_REG_EN
  logic                 rd_q;
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      rd_q <= mem_req_o & ~mem_we_o;
      if (rd_q) rdata_q <= mem_rdata_i;
    end
  end

  assign rdata_o = rdata_q;
`else
  assign rdata_o = mem_rdata_i;
`endif

endmodule
